// File: rtl/polygon_edge_controller.sv
// polygon_edge_controller: finds the bounding-box minimum of up to MAX_VERTS vertices, then issues
// one line-draw request per polygon edge relative to it. Optional open paths: `POLYGON_OPEN_PATH_EN.
module polygon_edge_controller #(
   parameter int COORD_W   = 8,
   parameter int MAX_VERTS = 4,
   parameter int VCNT_W    = $clog2(MAX_VERTS+1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [VCNT_W-1:0]                vert_count,
   input  logic [MAX_VERTS*2*COORD_W-1:0]   coordinates,
`ifdef POLYGON_OPEN_PATH_EN
   input  logic                             open_path,
`endif
   input  logic                             draw_done,
   output logic                             reset_buff,
   output logic                             draw_en,
   output logic [COORD_W-1:0]               x0,
   output logic [COORD_W-1:0]               y0,
   output logic [COORD_W-1:0]               x1,
   output logic [COORD_W-1:0]               y1,
   output logic                             busy,
   output logic                             bla_done,
   output logic                             error,
   output logic [2:0]                       dbg_state
);

   localparam int IDX_W = (MAX_VERTS > 1) ? $clog2(MAX_VERTS) : 1;
   localparam logic [VCNT_W-1:0] N_MIN = VCNT_W'(2);
   localparam logic [VCNT_W-1:0] N_MAX = VCNT_W'(MAX_VERTS);

   typedef enum logic [2:0] {
      IDLE, MIN_CALC, RESET, DRAW, GAP, DONE, DONE_WAIT, ERR
   } state_t;

   state_t state, state_next;

   logic [COORD_W-1:0] vx_q [MAX_VERTS];
   logic [COORD_W-1:0] vy_q [MAX_VERTS];
   logic [COORD_W-1:0] min_x, min_y;
   logic [VCNT_W-1:0]  n_q;
   logic               open_q, open_in;
   logic [IDX_W-1:0]   k_q, e_q, last_k, last_e, end_idx;
   logic               start_ok;

`ifdef POLYGON_OPEN_PATH_EN
   assign open_in = open_path;
`else
   assign open_in = 1'b0;
`endif

   assign start_ok = (vert_count >= N_MIN) && (vert_count <= N_MAX);
   assign last_k   = IDX_W'(n_q - VCNT_W'(1));
   // The closing edge wraps the last vertex back to vertex 0.
   assign end_idx  = (e_q == last_k) ? '0 : e_q + 1'b1;
   assign dbg_state = state;

   always_comb begin
      if (n_q == N_MIN)
         last_e = '0;
      else if (open_q)
         last_e = IDX_W'(n_q - N_MIN);
      else
         last_e = last_k;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_VERTS; i++) begin
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
         min_x  <= '0;
         min_y  <= '0;
         n_q    <= '0;
         open_q <= 1'b0;
         k_q    <= '0;
         e_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && start_ok) begin
                  for (int i = 0; i < MAX_VERTS; i++) begin
                     vx_q[i] <= coordinates[i*2*COORD_W +: COORD_W];
                     vy_q[i] <= coordinates[i*2*COORD_W+COORD_W +: COORD_W];
                  end
                  min_x  <= coordinates[0 +: COORD_W];
                  min_y  <= coordinates[COORD_W +: COORD_W];
                  n_q    <= vert_count;
                  open_q <= open_in;
                  k_q    <= IDX_W'(1);
               end
            end
            MIN_CALC: begin
               if (vx_q[k_q] < min_x) min_x <= vx_q[k_q];
               if (vy_q[k_q] < min_y) min_y <= vy_q[k_q];
               k_q <= k_q + 1'b1;
            end
            RESET:   e_q <= '0;
            GAP:     e_q <= e_q + 1'b1;
            default: ;
         endcase
      end
   end

   // Line handshake: draw_en rises on entry to DRAW and holds, with stable endpoints,
   // until the cycle draw_done is sampled high; draw_done at any other time is ignored.
   always_comb begin
      state_next = state;
      reset_buff = 1'b0;
      draw_en    = 1'b0;
      x0         = '0;
      y0         = '0;
      x1         = '0;
      y1         = '0;
      busy       = (state != IDLE);
      bla_done   = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = start_ok ? MIN_CALC : ERR;
         end
         MIN_CALC: begin
            if (k_q == last_k) state_next = RESET;
         end
         RESET: begin
            reset_buff = 1'b1;
            state_next = DRAW;
         end
         DRAW: begin
            draw_en = 1'b1;
            x0 = vx_q[e_q] - min_x;
            y0 = vy_q[e_q] - min_y;
            x1 = vx_q[end_idx] - min_x;
            y1 = vy_q[end_idx] - min_y;
            if (draw_done) state_next = (e_q == last_e) ? DONE : GAP;
         end
         GAP:       state_next = DRAW;
         DONE: begin
            bla_done   = 1'b1;
            state_next = DONE_WAIT;
         end
         DONE_WAIT: state_next = IDLE;
         ERR: begin
            error      = 1'b1;
            state_next = IDLE;
         end
         default:   state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_polygon_edge_controller.sv
// Directed bench for polygon_edge_controller: expected edges are queued per primitive
// and popped as the controller raises draw_en.
module tb_polygon_edge_controller;
   localparam int COORD_W   = 8;
   localparam int MAX_VERTS = 4;
   localparam int VCNT_W    = $clog2(MAX_VERTS+1);

   logic clk = 1'b0;
   logic rst, start, draw_done;
   logic [VCNT_W-1:0] vert_count;
   logic [MAX_VERTS*2*COORD_W-1:0] coordinates;
   logic reset_buff, draw_en, busy, bla_done, error;
   logic [COORD_W-1:0] x0, y0, x1, y1;
   logic [2:0] dbg_state;
`ifdef POLYGON_OPEN_PATH_EN
   logic open_path;
`endif

   logic [4*COORD_W-1:0] exp_q [$];
   logic [COORD_W-1:0] tx [MAX_VERTS];
   logic [COORD_W-1:0] ty [MAX_VERTS];
   logic [37:0] all_out;
   int vectors = 0;
   int miscompares = 0;

   assign all_out = {reset_buff, draw_en, busy, bla_done, error, x0, y0, x1, y1};

   always #5 clk = ~clk;

   polygon_edge_controller #(.COORD_W(COORD_W), .MAX_VERTS(MAX_VERTS), .VCNT_W(VCNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .vert_count(vert_count), .coordinates(coordinates),
`ifdef POLYGON_OPEN_PATH_EN
      .open_path(open_path),
`endif
      .draw_done(draw_done), .reset_buff(reset_buff), .draw_en(draw_en),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .busy(busy), .bla_done(bla_done),
      .error(error), .dbg_state(dbg_state)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_v();
      for (int k = 0; k < MAX_VERTS; k++) begin
         tx[k] = '0;
         ty[k] = '0;
      end
   endtask

   task automatic set_v(input int k, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      tx[k] = x;
      ty[k] = y;
   endtask

   task automatic pack_v();
      for (int k = 0; k < MAX_VERTS; k++) begin
         coordinates[k*2*COORD_W +: COORD_W]         = tx[k];
         coordinates[k*2*COORD_W+COORD_W +: COORD_W] = ty[k];
      end
   endtask

   task automatic push_e(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
      exp_q.push_back({a, b, c, d});
   endtask

   // Reference: true per-axis minimum over the n valid vertices, edges in ring order.
   task automatic model_push(input int n, input bit open);
      logic [COORD_W-1:0] mx, my;
      int ne, t;
      mx = tx[0];
      my = ty[0];
      for (int k = 1; k < n; k++) begin
         if (tx[k] < mx) mx = tx[k];
         if (ty[k] < my) my = ty[k];
      end
      ne = (n == 2) ? 1 : (open ? n - 1 : n);
      for (int e = 0; e < ne; e++) begin
         t = (e + 1) % n;
         exp_q.push_back({tx[e] - mx, ty[e] - my, tx[t] - mx, ty[t] - my});
      end
   endtask

   task automatic wait_draw(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (draw_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic run_poly(input int n, input bit open);
      bit ok;
      int ne;
      logic [4*COORD_W-1:0] exp_e;
      pack_v();
      vert_count = VCNT_W'(n);
      start = 1'b1;
`ifdef POLYGON_OPEN_PATH_EN
      open_path = open;
`endif
      tick();
      start = 1'b0;
      coordinates = {$urandom, $urandom};
`ifdef POLYGON_OPEN_PATH_EN
      open_path = ~open;
`endif
      for (int j = 1; j < n; j++) begin
         chk("min_calc_busy", busy, 1);
         chk("early_reset_buff", reset_buff, 0);
         chk("early_draw_en", draw_en, 0);
         tick();
      end
      chk("reset_buff_latency", reset_buff, 1);
      chk("reset_buff_no_draw", draw_en, 0);
      tick();
      chk("first_draw_latency", draw_en, 1);
      chk("reset_buff_single", reset_buff, 0);
      ne = exp_q.size();
      for (int e = 0; e < ne; e++) begin
         wait_draw(ok);
         if (!ok) begin
            chk("draw_wait", draw_en, 1);
            exp_q.delete();
            break;
         end
         exp_e = exp_q.pop_front();
         chk("edge_points", {x0, y0, x1, y1}, exp_e);
         tick();
         chk("edge_stable", {x0, y0, x1, y1}, exp_e);
         chk("edge_held", draw_en, 1);
         draw_done = 1'b1;
         tick();
         draw_done = 1'b0;
         if (e < ne - 1) begin
            chk("gap_draw_en", draw_en, 0);
            chk("gap_points", {x0, y0, x1, y1}, 0);
            chk("gap_no_done", bla_done, 0);
            tick();
         end else begin
            chk("bla_done_pulse", bla_done, 1);
            chk("done_no_draw", draw_en, 0);
            tick();
            chk("done_wait_busy", busy, 1);
            chk("bla_done_single", bla_done, 0);
            chk("done_wait_no_draw", draw_en, 0);
            tick();
            chk("idle_after_done", busy, 0);
         end
      end
      chk("queue_drained", exp_q.size(), 0);
      tick();
      chk("no_extra_draw", draw_en, 0);
   endtask

   task automatic run_err(input int vc);
      vert_count = VCNT_W'(vc);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_pulse", error, 1);
      chk("err_no_reset_buff", reset_buff, 0);
      chk("err_no_draw", draw_en, 0);
      tick();
      chk("err_busy_low", busy, 0);
      chk("err_single", error, 0);
      chk("err_no_reset_buff2", reset_buff, 0);
   endtask

   task automatic load_triangle();
      clear_v();
      set_v(0, 10, 20);
      set_v(1, 30, 5);
      set_v(2, 15, 40);
   endtask

   task automatic push_triangle();
      push_e(0, 15, 20, 0);
      push_e(20, 0, 5, 35);
      push_e(5, 35, 0, 15);
   endtask

   initial begin
      bit ok;
      int n;
      rst = 1'b1;
      start = 1'b0;
      draw_done = 1'b0;
      vert_count = '0;
      coordinates = '0;
`ifdef POLYGON_OPEN_PATH_EN
      open_path = 1'b0;
`endif
      repeat (3) tick();
      chk("reset_outputs", all_out, 0);
      chk("reset_state", dbg_state, 0);
      rst = 1'b0;
      tick();
      chk("idle_outputs", all_out, 0);

      load_triangle();
      push_triangle();
      run_poly(3, 1'b0);

      clear_v();
      set_v(0, 50, 60);
      set_v(1, 40, 70);
      push_e(10, 0, 0, 10);
      run_poly(2, 1'b0);

      clear_v();
      set_v(0, 0, 9);
      set_v(1, 9, 9);
      set_v(2, 9, 0);
      set_v(3, 0, 0);
      push_e(0, 9, 9, 9);
      push_e(9, 9, 9, 0);
      push_e(9, 0, 0, 0);
      push_e(0, 0, 0, 9);
      run_poly(4, 1'b0);

      for (int r = 0; r < 4; r++) begin
         clear_v();
         n = $urandom_range(2, MAX_VERTS);
         for (int k = 0; k < n; k++) set_v(k, COORD_W'($urandom_range(0, 255)),
                                             COORD_W'($urandom_range(0, 255)));
         model_push(n, 1'b0);
         run_poly(n, 1'b0);
      end

      run_err(1);
      run_err(5);
      run_err(0);

      // Reset while the second edge is being drawn, with draw_done pending.
      load_triangle();
      pack_v();
      vert_count = VCNT_W'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_draw(ok);
      chk("rst_first_draw", draw_en, 1);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      tick();
      chk("rst_in_edge1", {draw_en, x0, y0, x1, y1}, {1'b1, 8'd20, 8'd0, 8'd5, 8'd35});
      rst = 1'b1;
      draw_done = 1'b1;
      tick();
      rst = 1'b0;
      draw_done = 1'b0;
      chk("rst_mid_outputs", all_out, 0);
      chk("rst_mid_state", dbg_state, 0);
      for (int i = 0; i < 4; i++) begin
         draw_done = i[0];
         tick();
         chk("idle_ignores_draw_done", all_out, 0);
      end
      draw_done = 1'b0;

      load_triangle();
      push_triangle();
      run_poly(3, 1'b0);

`ifdef POLYGON_OPEN_PATH_EN
      load_triangle();
      push_e(0, 15, 20, 0);
      push_e(20, 0, 5, 35);
      run_poly(3, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/polygon_edge_controller.md
Name: polygon_edge_controller

Overview:
- Parametrised successor to the two/three-vertex line-draw controller.
- Accepts a packed list of up to MAX_VERTS vertices and computes the true bounding-box minimum (x and y tracked independently), one vertex per cycle.
- Issues one Bresenham line-draw request per polygon edge, with coordinates relative to that minimum.
- Sits between the instruction decoder and the line-draw engine / local frame buffer.

Parameters:
- COORD_W, 8, bits per coordinate component.
- MAX_VERTS, 4, maximum vertices per primitive (>=3).
- VCNT_W, $clog2(MAX_VERTS+1), width of the vertex-count input.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin primitive; sampled only in IDLE.
- vert_count  input  VCNT_W  number of valid vertices.
- coordinates  input  MAX_VERTS*2*COORD_W  vertex k: x at [k*2*COORD_W +: COORD_W], y at [k*2*COORD_W+COORD_W +: COORD_W].
- draw_done  input  1  line engine finished current edge.
- reset_buff  output  1  one-cycle clear pulse to the local buffer.
- draw_en  output  1  line request, held until draw_done.
- x0, y0, x1, y1  output  COORD_W each  relative edge endpoints.
- busy  output  1  high in every state except IDLE.
- bla_done  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse for an invalid vert_count.

Behaviour:
- Reset: on the rising clk edge with rst=1, state goes to IDLE from any state, including mid-draw. All outputs 0, min and edge registers cleared. A pending draw_done is discarded.
- States: IDLE, MIN_CALC, RESET, DRAW, GAP, DONE, DONE_WAIT, ERR.
- IDLE:
  - start=1 with 2<=vert_count<=MAX_VERTS: latch coordinates and vert_count into internal registers, set min_x/min_y to vertex 0, set index k=1, go to MIN_CALC.
  - start=1 with vert_count<2 or vert_count>MAX_VERTS: go to ERR.
- ERR: error=1 for one cycle, then IDLE. No reset_buff, no draw_en.
- MIN_CALC: each cycle compares vertex k against min_x and min_y independently and replaces each if strictly less. Increments k. Exits to RESET after the cycle processing vertex n-1, so it lasts n-1 cycles.
- RESET: reset_buff=1 for exactly one cycle. Edge index e=0. Go to DRAW.
- Edge set:
  - n=2: one edge, v0->v1.
  - n>=3: n edges, v_e->v_(e+1) for e<n-1, and closing edge v_(n-1)->v0.
- DRAW:
  - draw_en=1.
  - x0/y0 = start vertex minus min; x1/y1 = end vertex minus min. Results never negative, COORD_W bits, no wrap.
  - Endpoints are stable for the whole state.
  - On draw_done=1: go to DONE if e is the last edge, else go to GAP.
- GAP: draw_en=0, endpoints 0, e++ for one cycle, then DRAW.
- DONE: bla_done=1 for one cycle, then DONE_WAIT. DONE_WAIT lasts one cycle, then IDLE.
- Latency: start at cycle T gives reset_buff at T+n and first draw_en at T+n+1.
- Outputs outside DRAW: x0/y0/x1/y1 are 0, draw_en is 0.
- Ignored inputs:
  - start is ignored outside IDLE.
  - draw_done is ignored outside DRAW.
  - Input coordinate changes after latch have no effect.
- draw_done asserted in the same cycle DRAW is entered is accepted, giving a one-cycle DRAW.

Optional Feature:
- Macro: POLYGON_OPEN_PATH_EN.
- When defined: adds input port open_path (1 bit), latched with start. With open_path=1 and n>=3, the closing edge v_(n-1)->v0 is omitted, giving n-1 edges.
- When undefined: no port is added and primitives with n>=3 are always closed.

Test Plan:
- Triangle, n=3, (10,20),(30,5),(15,40), draw_done one cycle after each draw_en -> min (10,5). Edges in order:
  - (0,15)->(20,0)
  - (20,0)->(5,35)
  - (5,35)->(0,15)
  - reset_buff at T+3, first draw_en at T+4, a one-cycle GAP between edges, then one bla_done pulse.
- Line, n=2, (50,60),(40,70) -> min (40,60). Single edge (10,0)->(0,10), then bla_done. No second edge.
- Square at MAX_VERTS=4, (0,9),(9,9),(9,0),(0,0) -> min (0,0). Four edges in order, last edge (0,0)->(0,9). Verify min_y found at vertex 2, not vertex 0.
- vert_count=1, and separately vert_count=5 -> error pulse at T+1. No reset_buff or draw_en. busy low at T+2.
- rst asserted during DRAW of edge 1 -> next cycle all outputs 0 and state IDLE. A new start then runs the full sequence correctly. draw_done and start pulses in IDLE with start=0 produce no activity.
- With POLYGON_OPEN_PATH_EN and open_path=1, the triangle above -> only edges 0 and 1, then bla_done.
